// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one delayed memory port between NUM_REQ requesters.
// Latency: request seen in IDLE at cycle t -> one-cycle mem request pulse at t+1 -> ack at t+1+D.
// Backpressure: level requests are held by the requester until its one-cycle req_ack_o pulse.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_rd_i / req_wr_i       per-requester read / write request levels
//   req_addr_i / req_wr_data_i packed per-requester address and write data
//   req_rd_data_o             shared read-data return, qualified by req_ack_o
//   req_ack_o / req_err_o     one-hot completion pulse and its error flag
//   req_busy_o                one-hot: requester's command granted and in flight
//   mem_*                     command pulse, address, data and ack towards memory
// Optional build macro MEM_ARB_TIMEOUT_EN adds a WAIT-state watchdog that completes
// a hung command with req_err_o set after TIMEOUT_CYCLES cycles without mem_ack_i.
module mem_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_rd_i,
    input  logic [NUM_REQ-1:0]             req_wr_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wr_data_i,
    output logic [DATA_WIDTH-1:0]          req_rd_data_o,
    output logic [NUM_REQ-1:0]             req_ack_o,
    output logic [NUM_REQ-1:0]             req_busy_o,
    output logic [NUM_REQ-1:0]             req_err_o,
    output logic                           mem_rd_req_o,
    output logic                           mem_wr_req_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic [DATA_WIDTH-1:0]          mem_wr_data_o,
    input  logic [DATA_WIDTH-1:0]          mem_rd_data_i,
    input  logic                           mem_ack_i,
    input  logic                           mem_busy_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
    } cmd_t;

    state_e state_q, state_d;
    idx_t   grant_q, grant_d;
    idx_t   rr_ptr_q, rr_ptr_d;
    cmd_t   cmd_q, cmd_d;
    logic   mem_rd_req_q, mem_rd_req_d;
    logic   mem_wr_req_q, mem_wr_req_d;

    logic [NUM_REQ-1:0] pending;
    logic               win_vld;
    idx_t               win_idx;
    logic               done;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timed_out;
`endif

    // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int   cand;
        idx_t cand_idx;
        pending  = req_rd_i | req_wr_i;
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = idx_t'(cand);
            if (!win_vld && pending[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        cmd_d        = cmd_q;
        mem_rd_req_d = 1'b0;
        mem_wr_req_d = 1'b0;
        done         = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        timed_out    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    grant_d   = win_idx;
                    // Write wins when a requester raises both levels.
                    cmd_d.wr   = req_wr_i[win_idx];
                    cmd_d.addr = req_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_d.dat  = req_wr_data_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    // Pulse registers are loaded here so they are high during ISSUE only.
                    mem_wr_req_d = req_wr_i[win_idx];
                    mem_rd_req_d = ~req_wr_i[win_idx];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    done = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (wait_cnt_q == 8'(TIMEOUT_CYCLES)) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done) begin
            rr_ptr_d = (grant_q == idx_t'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d  = ST_IDLE;
        end
    end

    // Completion is combinational on mem_ack_i so the requester sees it in the ack cycle.
    always_comb begin
        req_ack_o     = '0;
        req_err_o     = '0;
        req_busy_o    = '0;
        req_rd_data_o = '0;
        if (state_q != ST_IDLE) begin
            req_busy_o[grant_q] = 1'b1;
        end
        if (done) begin
            req_ack_o[grant_q] = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            req_err_o[grant_q] = timed_out;
            if (!cmd_q.wr && !timed_out) begin
                req_rd_data_o = mem_rd_data_i;
            end
`else
            if (!cmd_q.wr) begin
                req_rd_data_o = mem_rd_data_i;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            cmd_q        <= '0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            cmd_q        <= cmd_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign mem_rd_req_o  = mem_rd_req_q;
    assign mem_wr_req_o  = mem_wr_req_q;
    assign mem_addr_o    = cmd_q.addr;
    assign mem_wr_data_o = cmd_q.dat;

    a_params: assert property (@(posedge clk_i)
        (NUM_REQ >= 2) && (NUM_REQ <= 8) && (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 255));

    // A requester must never raise read and write together.
    a_rd_wr_excl: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ST_IDLE) |-> ((req_rd_i & req_wr_i) == '0));

    // Memory must be ready whenever a command pulse is issued.
    a_mem_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        (mem_rd_req_o || mem_wr_req_o) |-> !mem_busy_i);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_rd = '0;
    logic [NR-1:0]     req_wr = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wr_data = '0;
    logic [DW-1:0]     req_rd_data;
    logic [NR-1:0]     req_ack, req_busy, req_err;
    logic              mem_rd_req, mem_wr_req;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wr_data;
    logic [DW-1:0]     mem_rd_data = '0;
    logic              mem_ack = 1'b0;
    logic              mem_busy = 1'b0;

    mem_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_rd_i(req_rd), .req_wr_i(req_wr),
        .req_addr_i(req_addr), .req_wr_data_i(req_wr_data),
        .req_rd_data_o(req_rd_data), .req_ack_o(req_ack),
        .req_busy_o(req_busy), .req_err_o(req_err),
        .mem_rd_req_o(mem_rd_req), .mem_wr_req_o(mem_wr_req),
        .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data),
        .mem_rd_data_i(mem_rd_data), .mem_ack_i(mem_ack), .mem_busy_i(mem_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] dat; } op_t;
    typedef struct { int who; logic [31:0] dat; bit err; int cyc; } rsp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] dat; int who; } mcmd_t;

    rsp_t  rsp_q[$];
    mcmd_t mcmd_q[$];
    op_t   bq[NR][$];

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dev_mem [logic [31:0]];
    int model_rr = 0;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : 32'h0;
    endfunction

    // ---------------- memory device: acks D cycles after the command pulse
    int mem_d = 5;
    bit mute  = 1'b0;
    initial begin
        bit          busy = 1'b0;
        int          cd = 0;
        bit          m_wr = 1'b0;
        logic [31:0] m_addr = '0, m_dat = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack     = 1'b0;
            mem_rd_data = $urandom;
            if (rst) begin
                busy = 1'b0;
                cd   = 0;
            end else begin
                if (busy) begin
                    cd--;
                    if (cd == 0) begin
                        busy = 1'b0;
                        if (!mute) begin
                            mem_ack = 1'b1;
                            if (m_wr) dev_mem[m_addr] = m_dat;
                            else      mem_rd_data = dev_rd(m_addr);
                        end
                    end
                end
            end
            mem_busy = busy;
            if (!rst && (mem_rd_req || mem_wr_req)) begin
                busy   = 1'b1;
                cd     = mem_d;
                m_wr   = mem_wr_req;
                m_addr = mem_addr;
                m_dat  = mem_wr_data;
            end
        end
    end

    // ---------------- response monitor
    initial begin
        forever begin
            @(negedge clk);
            if (|req_ack) begin
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    rsp_t e;
                    logic [63:0] oh;
                    e  = rsp_q.pop_front();
                    oh = 64'd1 << e.who;
                    check("ack_onehot", 64'(req_ack), oh);
                    check("ack_cycle", 64'(cyc), 64'(e.cyc));
                    check("rd_data", 64'(req_rd_data), 64'(e.dat));
                    check("err", 64'(req_err), e.err ? oh : 64'd0);
                    check("busy_at_ack", 64'(req_busy), oh);
                end
            end
        end
    end

    // ---------------- memory-command monitor
    initial begin
        bit prev_pulse = 1'b0;
        bit pulse;
        forever begin
            @(negedge clk);
            pulse = mem_rd_req | mem_wr_req;
            if (pulse) begin
                check("pulse_single_cycle", 64'(prev_pulse), 64'd0);
                if (mcmd_q.size() == 0) begin
                    fail_now("unexpected_mem_cmd");
                end else begin
                    mcmd_t m;
                    m = mcmd_q.pop_front();
                    check("mem_op", {62'd0, mem_rd_req, mem_wr_req}, {62'd0, !m.wr, m.wr});
                    check("mem_addr", 64'(mem_addr), 64'(m.addr));
                    check("mem_wr_data", 64'(mem_wr_data), 64'(m.dat));
                    check("busy_at_issue", 64'(req_busy), 64'd1 << m.who);
                end
            end
            prev_pulse = pulse;
        end
    end

    task automatic set_req(input int i, input bit en, input op_t op);
        req_rd[i] = en && !op.wr;
        req_wr[i] = en && op.wr;
        req_addr[i*AW +: AW]    = op.addr;
        req_wr_data[i*DW +: DW] = op.dat;
    endtask

    // Every requester starts its queued ops together and re-requests right after each ack.
    task automatic run_batch(input int d);
        int rem[NR];
        int idx[NR];
        int left, rr, w, c0, t, budget;
        bit active;
        logic [NR-1:0] acks;
        op_t op, nop;
        nop = '{0, 32'h0, 32'h0};
        mem_d = d;
        @(posedge clk);
        #1;
        c0 = cyc;
        left = 0;
        for (int i = 0; i < NR; i++) begin
            rem[i] = bq[i].size();
            idx[i] = 0;
            left  += rem[i];
        end
        // Reference: each completion hands priority to the next index after the winner.
        rr = model_rr;
        t  = c0 + 1 + d;
        while (left > 0) begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (rr + k) % NR;
                if (w < 0 && rem[c] > 0) w = c;
            end
            op = bq[w][idx[w]];
            idx[w]++;
            rem[w]--;
            left--;
            rsp_q.push_back('{w, op.wr ? 32'h0 : ref_rd(op.addr), 1'b0, t});
            mcmd_q.push_back('{op.wr, op.addr, op.dat, w});
            if (op.wr) ref_mem[op.addr] = op.dat;
            t += 2 + d;
            rr = (w + 1) % NR;
        end
        model_rr = rr;
        for (int i = 0; i < NR; i++) begin
            idx[i] = 0;
            if (bq[i].size() > 0) set_req(i, 1'b1, bq[i][0]);
            else                  set_req(i, 1'b0, nop);
        end
        budget = 0;
        active = 1'b1;
        while (active && budget < 2000) begin
            @(negedge clk);
            acks = req_ack;
            @(posedge clk);
            #1;
            budget++;
            active = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (acks[i]) begin
                    idx[i]++;
                    if (idx[i] < bq[i].size()) set_req(i, 1'b1, bq[i][idx[i]]);
                    else                       set_req(i, 1'b0, nop);
                end
                if (idx[i] < bq[i].size()) active = 1'b1;
            end
        end
        if (active) fail_now("batch_cycle_budget");
        for (int i = 0; i < NR; i++) bq[i].delete();
    endtask

    initial begin
        op_t op, nop;
        int c0;
        nop = '{0, 32'h0, 32'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_rd_req", 64'(mem_rd_req), 64'd0);
        check("rst_mem_wr_req", 64'(mem_wr_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wr_data", 64'(mem_wr_data), 64'd0);
        check("rst_busy", 64'(req_busy), 64'd0);
        check("rst_ack_err_data", {req_ack, req_err, req_rd_data}, 64'd0);
        rst = 1'b0;

        // Single read, D=5
        dev_mem[32'h40] = 32'h1234;
        ref_mem[32'h40] = 32'h1234;
        bq[0].push_back('{0, 32'h40, 32'h5555_0000});
        run_batch(5);

        // Write then read back from requester 1
        bq[1].push_back('{1, 32'h80, 32'hDEAD_BEEF});
        bq[1].push_back('{0, 32'h80, 32'h0});
        run_batch(3);

        // Wrap-around: pointer now at 2, requesters 2 and 0 pending
        bq[2].push_back('{0, 32'h40, 32'h1});
        bq[0].push_back('{0, 32'h80, 32'h2});
        run_batch(2);

        // Contention: everyone pending continuously, two reads each
        for (int i = 0; i < NR; i++) begin
            bq[i].push_back('{0, 32'h40, 32'h0});
            bq[i].push_back('{0, 32'h80, 32'h0});
        end
        run_batch(1);

        // Reset two cycles after ISSUE
        mem_d = 8;
        @(posedge clk);
        #1;
        c0 = cyc;
        op = '{0, 32'h40, 32'h77};
        mcmd_q.push_back('{0, 32'h40, 32'h77, 0});
        set_req(0, 1'b1, op);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        set_req(0, 1'b0, nop);
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(req_busy), 64'd0);
        check("midrst_mem_req", {62'd0, mem_rd_req, mem_wr_req}, 64'd0);
        check("midrst_elapsed", 64'(cyc - c0), 64'd4);
        rst = 1'b0;
        model_rr = 0;
        repeat (12) @(posedge clk);
        bq[0].push_back('{0, 32'h40, 32'h9});
        run_batch(4);

        // Random batches
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < NR; i++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) begin
                    op.wr   = 1'($urandom_range(0, 1));
                    op.addr = 32'h40 + (32'($urandom_range(0, 7)) << 2);
                    op.dat  = $urandom;
                    bq[i].push_back(op);
                end
            end
            run_batch($urandom_range(1, 6));
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never acks: watchdog completes with error
        begin
            bit seen;
            mute  = 1'b1;
            mem_d = 3;
            @(posedge clk);
            #1;
            c0 = cyc;
            op = '{0, 32'h40, 32'h0};
            rsp_q.push_back('{0, 32'h0, 1'b1, c0 + 2 + TO});
            mcmd_q.push_back('{0, 32'h40, 32'h0, 0});
            set_req(0, 1'b1, op);
            seen = 1'b0;
            for (int k = 0; k < TO + 50 && !seen; k++) begin
                @(negedge clk);
                if (req_ack[0]) seen = 1'b1;
            end
            if (!seen) fail_now("timeout_never_acked");
            @(posedge clk);
            #1;
            set_req(0, 1'b0, nop);
            mute = 1'b0;
            model_rr = 1;
            bq[1].push_back('{0, 32'h80, 32'h0});
            run_batch(2);
        end
`endif

        repeat (10) @(posedge clk);
        #1;
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        check("mem_cmd_queue_drained", 64'(mcmd_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single mem_delayed port between N requesters, for example instruction fetch, load/store unit, and a future DMA engine.
- Uses round-robin arbitration.
- Latches the winner's command, issues it to memory as a one-cycle rd_req/wr_req pulse, waits for memory ack, then routes ack and rd_data back to the winner.
- Sits between the core-side requesters and mem_delayed.

Parameters:
- num_req, 2, number of requesters (2..8).
- addr_width, 32, address width; matches the memory.
- data_width, 32, data width; matches the memory.
- timeout_cycles, 255, WAIT-state watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_rd  in  num_req  per-requester read request; level, held until that requester's ack.
- req_wr  in  num_req  per-requester write request; level, held until that requester's ack.
- req_addr  in  num_req*addr_width  packed addresses; requester i at bits [i*addr_width +: addr_width].
- req_wr_data  in  num_req*data_width  packed write data.
- req_rd_data  out  data_width  shared read-data return; valid only with a req_ack bit.
- req_ack  out  num_req  one-hot completion pulse.
- req_busy  out  num_req  bit i high while requester i's command is granted and in flight.
- req_err  out  num_req  completion-with-error flag; qualifies req_ack.
- mem_rd_req  out  1  to memory rd_req.
- mem_wr_req  out  1  to memory wr_req.
- mem_addr  out  addr_width  to memory addr.
- mem_wr_data  out  data_width  to memory wr_data.
- mem_rd_data  in  data_width  from memory rd_data.
- mem_ack  in  1  from memory ack.
- mem_busy  in  1  from memory busy; monitored by assertion only.

Behaviour:
- State machine: IDLE, ISSUE, WAIT. The state, grant index, rr pointer, and latched command are registered.
- Reset: state=IDLE, rr_ptr=0, grant=0, latched addr/data/op=0.
  - Registered outputs mem_rd_req, mem_wr_req, mem_addr, mem_wr_data all 0.
  - req_busy=0; req_ack, req_err and req_rd_data are 0 because state is IDLE.
- IDLE:
  - pending[i] = req_rd[i] | req_wr[i].
  - Winner = first pending index searching rr_ptr, rr_ptr+1, ... modulo num_req, with wrap-around.
  - If any request is pending: latch the winner's index, address, wr_data and op (write if req_wr set, else read), then go to ISSUE.
  - If nothing is pending: stay in IDLE.
- Simultaneous rd and wr from one requester: write wins. This case is also flagged by an assertion.
- ISSUE (exactly one cycle): mem_rd_req or mem_wr_req=1 for this cycle only, with mem_addr and mem_wr_data driven from the latch. Next state is WAIT.
- mem_addr and mem_wr_data hold their latched values until the next grant.
- WAIT: on mem_ack=1, in the same cycle and combinationally:
  - req_ack[grant]=1;
  - req_rd_data=mem_rd_data for reads, 0 for writes;
  - req_err=0.
- At the edge ending the ack cycle: rr_ptr = (grant+1) mod num_req, then go to IDLE.
- The requester must drop its request at that same edge. Because the arbiter re-enters IDLE on that edge, no duplicate issue occurs.
- req_busy[grant]=1 throughout ISSUE and WAIT; 0 otherwise.
- mem_ack seen in IDLE or ISSUE is ignored; no ack is forwarded.
- Request changes while that requester is granted are ignored because the command is latched.
- Requests withdrawn before grant are never issued.
- Latency: request seen in IDLE at cycle t -> mem request pulse at t+1 -> ack at t+1+D, where D is the memory delay. Minimum arbiter overhead is 1 cycle.
- Fairness: with all requesters pending continuously, grants rotate 0,1,...,num_req-1,0,...
- Reset asserted mid-transaction returns to reset state next edge. Memory shares rst, so the in-flight command is discarded and no ack is forwarded.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Enabled: an 8-bit cycle counter clears on entry to WAIT and increments each WAIT cycle without mem_ack.
- When the counter reaches timeout_cycles:
  - req_ack[grant]=1, req_err[grant]=1, req_rd_data=0 in that cycle;
  - rr_ptr advances;
  - state returns to IDLE.
- A late mem_ack after a timeout arrives in IDLE/ISSUE and is ignored.
- Disabled: no counter; WAIT persists until mem_ack; req_err tied to 0.

Test Plan:
- Single read: num_req=2, mem delay D=5, mem[0x40>>2]=0x1234; req_rd[0]=1, addr=0x40 -> one-cycle mem_rd_req with mem_addr=0x40; req_ack[0] pulses 6 cycles after request; req_rd_data=0x1234; req_busy[0] high in between.
- Write then read-back: requester 1 writes 0xDEADBEEF to 0x80, then reads 0x80 -> write acked with req_rd_data=0; read returns 0xDEADBEEF on req_ack[1].
- Contention: both requesters hold reads from reset -> grant order 0,1,0,1 over 4 transactions; exactly one mem request pulse per transaction; no overlap.
- Wrap-around: num_req=3, only requesters 2 and 0 pending, rr_ptr=2 -> grants 2 then 0; rr_ptr ends at 1.
- Reset mid-WAIT: assert rst 2 cycles after ISSUE -> next cycle state IDLE, req_busy=0; no req_ack; the subsequent request is serviced normally.
- With MEM_ARB_TIMEOUT_EN, timeout_cycles=10, memory ena held low -> req_ack[0]=1 and req_err[0]=1 after 10 WAIT cycles; arbiter returns to IDLE.
